// File: rtl/ecg_uart_framer_pkg.sv
// Shared widths, sync byte, state encodings and baud-divider helper for the
// ECG sample UART framer.
package ecg_uart_framer_pkg;

    localparam int         ADC_W     = 12;
    localparam int         SEQ_W     = 4;
    localparam int         ENTRY_W   = SEQ_W + ADC_W;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // FR_IDLE: the next byte to send is a SYNC taken straight from the FIFO head.
    typedef enum logic [1:0] {FR_IDLE, FR_HDR, FR_LO} frame_state_t;

    function automatic int clks_per_bit(input int fclk, input int baud);
        return (fclk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/ecg_uart_framer_uart_tx.sv
// 8N1 byte serialiser. A byte offered while o_ready is high starts one edge
// later, so a byte accepted near the end of a stop bit follows it with no gap.
module uart_tx_8n1
    import ecg_uart_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_ready,
    output logic       o_done
);
    localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_hold;
    logic             r_queued;
    logic             r_tx;
    logic             w_bit_end;
    logic             w_accept;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign o_ready   = !r_queued && ((r_state == TX_IDLE) ||
                                     (r_state == TX_STOP && r_cnt == CNT_PRELAST));
    assign w_accept  = i_start && o_ready;
    // High in the final cycle of a stop bit that is not followed by another byte.
    assign o_done    = (r_state == TX_STOP) && w_bit_end && !r_queued;
    assign o_tx      = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_hold   <= '0;
            r_queued <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold   <= i_byte;
                r_queued <= 1'b1;
            end
            case (r_state)
                TX_IDLE: begin
                    if (r_queued) begin
                        r_state  <= TX_START;
                        r_tx     <= 1'b0;
                        r_cnt    <= '0;
                        r_shift  <= r_hold;
                        r_queued <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_queued) begin
                            r_state  <= TX_START;
                            r_tx     <= 1'b0;
                            r_shift  <= r_hold;
                            r_queued <= 1'b0;
                        end else begin
                            r_state <= TX_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ecg_uart_framer.sv
// Buffers sequence-tagged ADC samples in a small FIFO and streams each one as a
// 3-byte UART frame {A5, {seq,data[11:8]}, data[7:0]}.
module ecg_uart_framer
    import ecg_uart_framer_pkg::*;
#(
    parameter int FCLK       = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] i_data,
    input  logic             i_dv,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_overflow
);
    localparam int CLKS_PER_BIT = clks_per_bit(FCLK, BAUD);
    localparam int AW           = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [SEQ_W-1:0]   r_seq;
    logic [ENTRY_W-1:0] r_entry;
    frame_state_t       r_fstate;
    logic               r_busy;
    logic               r_overflow;

    logic       w_empty, w_full, w_start, w_ready, w_done, w_take, w_pop, w_push;
    logic [7:0] w_byte;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A new frame begins by handing the SYNC byte over directly from FIFO state;
    // the entry itself is popped on that same handshake.
    assign w_start = (r_fstate != FR_IDLE) || !w_empty;
    assign w_take  = w_start && w_ready;
    assign w_pop   = w_take && (r_fstate == FR_IDLE);
    assign w_push  = i_dv && (!w_full || w_pop);

    always_comb begin
        w_byte = SYNC_BYTE;
        if (r_fstate == FR_HDR) begin
            w_byte = r_entry[ENTRY_W-1:ENTRY_W-8];
        end else if (r_fstate == FR_LO) begin
            w_byte = r_entry[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {r_seq, i_data};
        end
        if (w_pop) begin
            r_entry <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_seq      <= '0;
            r_fstate   <= FR_IDLE;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_dv && !w_push;
            if (i_dv) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_take) begin
                case (r_fstate)
                    FR_IDLE: r_fstate <= FR_HDR;
                    FR_HDR:  r_fstate <= FR_LO;
                    default: r_fstate <= FR_IDLE;
                endcase
            end
            if (w_push) begin
                r_busy <= 1'b1;
            end else if (w_done && w_empty && r_fstate == FR_IDLE) begin
                r_busy <= 1'b0;
            end
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_byte (w_byte),
        .o_tx   (o_tx),
        .o_ready(w_ready),
        .o_done (w_done)
    );

    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_ecg_uart_framer.sv
// Bench for ecg_uart_framer: a line decoder turns o_tx back into bytes and a
// queue-based frame model predicts them from the captured samples.
module tb_ecg_uart_framer;
    localparam int FCLK      = 100_000_000;
    localparam int BAUD      = 5_000_000;
    localparam int CPB       = 20;          // 100 MHz / 5 Mbaud
    localparam int DEPTH     = 8;
    localparam int FRAME_CYC = 30 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_dv = 1'b0;
    logic [11:0] i_data = '0;
    logic        o_tx, o_busy, o_overflow;

    always #5 clk = ~clk;

    ecg_uart_framer #(
        .FCLK(FCLK), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_dv(i_dv),
        .o_tx(o_tx), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_cnt = 0;
    int model_seq = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: every i_dv consumes a sequence number; an accepted
    // sample becomes three bytes on the wire.
    task automatic capture(input logic [11:0] d, input bit accepted);
        logic [3:0] s;
        s = 4'(model_seq);
        if (accepted) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back({s, d[11:8]});
            exp_q.push_back(d[7:0]);
        end
        $display("[TB] sample seq=%0d data=0x%03h %s", s, d, accepted ? "queued" : "dropped");
        model_seq = (model_seq + 1) % 16;
    endtask

    task automatic send(input logic [11:0] d);
        @(negedge clk);
        i_data = d;
        i_dv   = 1'b1;
        capture(d, 1'b1);
        @(negedge clk);
        i_dv = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        i_dv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rx_q.delete();
        model_seq = 0;
    endtask

    task automatic drain(input string tag);
        int budget;
        int waited;
        logic [7:0] e;
        logic [7:0] r;
        budget = exp_q.size() * 10 * CPB + 4 * FRAME_CYC;
        waited = 0;
        while (rx_q.size() < exp_q.size() && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= budget) check({tag, "_timeout"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                check(tag, int'(r), int'(e));
            end else begin
                check({tag, "_missing"}, -1, int'(e));
            end
        end
        check({tag, "_extra"}, rx_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (o_overflow === 1'b1) ovf_cnt++;
    end

    // Line decoder: one full frame of samples per byte, every bit must be flat.
    initial begin : line_monitor
        logic       smp [10*CPB];
        logic [7:0] b;
        int         odd;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && o_tx === 1'b0) begin
                aborted = 1'b0;
                smp[0]  = o_tx;
                for (int i = 1; i < 10 * CPB; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = o_tx;
                end
                if (!aborted) begin
                    odd = 0;
                    for (int bi = 0; bi < 10; bi++)
                        for (int c = 1; c < CPB; c++)
                            if (smp[bi*CPB+c] !== smp[bi*CPB]) odd++;
                    for (int bi = 0; bi < 8; bi++) b[bi] = smp[(bi+1)*CPB + CPB/2];
                    check("bit_width", odd, 0);
                    check("stop_bit", int'(smp[9*CPB + CPB/2]), 1);
                    rx_q.push_back(b);
                    $display("[TB] rx byte 0x%02h", b);
                end
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [11:0] d;
        int ovf_base;
        logic [11:0] spaced [3];
        spaced[0] = 12'h75F;
        spaced[1] = 12'h4E8;
        spaced[2] = 12'h01A;

        repeat (5) @(negedge clk);
        check("rst_tx", int'(o_tx), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ovf", int'(o_overflow), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single sample: latency, busy window, frame content.
        ovf_base = ovf_cnt;
        @(negedge clk);
        i_data = 12'h75F;
        i_dv   = 1'b1;
        capture(12'h75F, 1'b1);
        @(posedge clk);
        @(negedge clk);
        i_dv = 1'b0;
        @(posedge clk); #1;
        check("lat_k1_tx", int'(o_tx), 1);
        check("lat_k1_busy", int'(o_busy), 1);
        @(posedge clk); #1;
        check("lat_k2_tx", int'(o_tx), 0);
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        check("busy_hold", int'(o_busy), 1);
        @(posedge clk); #1;
        check("busy_fall", int'(o_busy), 0);
        check("idle_tx", int'(o_tx), 1);
        drain("t1");
        check("t1_ovf", ovf_cnt - ovf_base, 0);

        // Three spaced samples.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(spaced[i]);
            repeat (FRAME_CYC + 100) @(negedge clk);
        end
        drain("t2");

        // All-ones sample.
        do_reset();
        send(12'hFFF);
        drain("t6");

        // Burst of DEPTH+2 samples on consecutive cycles.
        do_reset();
        ovf_base = ovf_cnt;
        @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) begin
            d = 12'($urandom);
            i_data = d;
            i_dv   = 1'b1;
            capture(d, i < DEPTH + 1);
            if (i == DEPTH + 1) check("ovf_early", int'(o_overflow), 0);
            @(negedge clk);
        end
        i_dv = 1'b0;
        check("ovf_pulse", int'(o_overflow), 1);
        @(negedge clk);
        check("ovf_clear", int'(o_overflow), 0);
        drain("t3");
        send(12'($urandom));
        drain("t3_next");
        check("t3_ovf_count", ovf_cnt - ovf_base, 1);

        // Reset in the middle of a frame with two samples queued.
        do_reset();
        for (int i = 0; i < 3; i++) send(12'($urandom));
        repeat (300) @(negedge clk);
        check("pre_rst_busy", int'(o_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx", int'(o_tx), 1);
        check("midrst_busy", int'(o_busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rx_q.delete();
        model_seq = 0;
        repeat (3 * FRAME_CYC) @(negedge clk);
        check("post_rst_quiet", rx_q.size(), 0);
        check("post_rst_busy", int'(o_busy), 0);
        send(12'h123);
        drain("t4");

        // Sequence wrap over 17 spaced samples.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(12'($urandom));
            repeat ($urandom_range(620, 900)) @(negedge clk);
        end
        drain("t5");

        // Random gaps, frames queue up and leave back-to-back.
        do_reset();
        ovf_base = ovf_cnt;
        for (int i = 0; i < 10; i++) begin
            send(12'($urandom));
            repeat ($urandom_range(200, 700)) @(negedge clk);
        end
        drain("rand");
        check("rand_ovf", ovf_cnt - ovf_base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
